// File: rtl/arbitro_rr4_pkg.sv
`default_nettype none
// Shared constants, FSM encoding and one-hot helper for the arbitro_rr4 arbiter.
// Revision: 1.0
package arbitro_rr4_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int NUM_PORTS  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [1:0] onehot_idx(input logic [NUM_PORTS-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_rr4_rr_pick4.sv
`default_nettype none
// rr_pick4: combinational round-robin picker; first request at or after ptr wins.
// Revision: 1.0
module rr_pick4
  import arbitro_rr4_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [1:0]           ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 any
);

  logic [2*NUM_PORTS-1:0] dbl;
  logic [NUM_PORTS-1:0]   rot;
  logic [NUM_PORTS-1:0]   rot_g;
  logic [2*NUM_PORTS-1:0] g_dbl;

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  assign dbl   = {req, req};
  assign rot   = dbl[ptr +: NUM_PORTS];
  assign rot_g = rot & (~rot + NUM_PORTS'(1));
  assign g_dbl = {{NUM_PORTS{1'b0}}, rot_g} << ptr;
  assign grant = g_dbl[NUM_PORTS-1:0] | g_dbl[2*NUM_PORTS-1:NUM_PORTS];
  assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/arbitro_rr4.sv
`default_nettype none
// arbitro_rr4: drains four upstream FIFOs round-robin into one downstream FIFO.
// Revision: 1.0
module arbitro_rr4
  import arbitro_rr4_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int POP_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          reset_L,
  input  logic [NUM_PORTS-1:0]          fifo_empty,
  input  logic [NUM_PORTS*DATA_W-1:0]   fifo_data,
  output logic [NUM_PORTS-1:0]          pop,
  input  logic                          down_pausa,
  input  logic                          down_full,
  output logic                          push_out,
  output logic [DATA_W-1:0]             data_out,
  output logic [1:0]                    src_id,
  output logic [CNT_W-1:0]              fwd_count,
  output logic                          idle,
  output logic                          error
);

  state_t                     state, state_nx;
  logic                       armed;
  logic [1:0]                 ptr;
  logic [NUM_PORTS-1:0]       hold_mask;
  logic [NUM_PORTS-1:0]       eligible;
  logic [NUM_PORTS-1:0]       grant;
  logic                       any_elig;
  logic                       blocked;
  logic                       issue;
  logic [1:0]                 grant_idx;
  logic [POP_LAT-1:0]         pipe_vld;
  logic [POP_LAT-1:0]         pipe_vld_nx;
  logic [POP_LAT-1:0][1:0]    pipe_src;
  logic [DATA_W-1:0]          in_word [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in_word
    assign in_word[g] = fifo_data[g*DATA_W +: DATA_W];
  end

  // Empty flags lag a pop by a cycle, so last cycle's pop target is masked off.
  // armed keeps pop low until the first edge after reset is released.
  assign eligible = ~fifo_empty & ~hold_mask & {NUM_PORTS{armed}};
  assign blocked  = down_pausa | down_full;

  rr_pick4 u_pick (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant),
    .any   (any_elig)
  );

  assign grant_idx   = onehot_idx(grant);
  assign pop         = issue ? grant : '0;
  assign pipe_vld_nx = (pipe_vld << 1) | POP_LAT'(issue);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_elig && !blocked) begin
          state_nx = ACTIVE;
          issue    = 1'b1;
        end
      end
      ACTIVE: begin
        if (blocked)        state_nx = HOLD;
        else if (!any_elig) state_nx = IDLE;
        else                issue    = 1'b1;
      end
      HOLD: begin
        if (!blocked) state_nx = any_elig ? ACTIVE : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      armed     <= 1'b0;
      ptr       <= 2'd0;
      hold_mask <= '0;
      pipe_vld  <= '0;
      pipe_src  <= '0;
      push_out  <= 1'b0;
      data_out  <= '0;
      src_id    <= 2'd0;
      fwd_count <= '0;
      idle      <= 1'b1;
      error     <= 1'b0;
    end else begin
      armed     <= 1'b1;
      hold_mask <= pop;
      if (issue) ptr <= grant_idx + 2'd1;

      pipe_vld    <= pipe_vld_nx;
      pipe_src[0] <= grant_idx;
      for (int s = 1; s < POP_LAT; s++) pipe_src[s] <= pipe_src[s-1];

      // Tail of the pipeline lines up with the FIFO's read data.
      push_out <= pipe_vld[POP_LAT-1];
      if (pipe_vld[POP_LAT-1]) begin
        data_out <= in_word[pipe_src[POP_LAT-1]];
        src_id   <= pipe_src[POP_LAT-1];
        if (fwd_count != '1) fwd_count <= fwd_count + CNT_W'(1);
      end

      if (push_out && down_full) error <= 1'b1;
      idle <= (state_nx == IDLE) && (pipe_vld_nx == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr4.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for arbitro_rr4: FIFO models, scoreboard and vector table.
// Revision: 1.0
module tb_arbitro_rr4;

  localparam int DW = 6;

  logic           clk = 1'b0;
  logic           reset_L = 1'b1;
  logic [3:0]     fifo_empty;
  logic [4*DW-1:0] fifo_data;
  logic [3:0]     pop;
  logic           down_pausa = 1'b0;
  logic           down_full = 1'b0;
  logic           push_out;
  logic [DW-1:0]  data_out;
  logic [1:0]     src_id;
  logic [7:0]     fwd_count;
  logic           idle;
  logic           error;

  always #5 clk = ~clk;

  arbitro_rr4 #(.DATA_W(DW), .POP_LAT(2), .CNT_W(8)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .pop        (pop),
    .down_pausa (down_pausa),
    .down_full  (down_full),
    .push_out   (push_out),
    .data_out   (data_out),
    .src_id     (src_id),
    .fwd_count  (fwd_count),
    .idle       (idle),
    .error      (error)
  );

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } exp_t;

  typedef struct packed {
    logic [3:0][3:0] cnt;
    logic [3:0]      n;
    logic [7:0][1:0] seq;
    logic [7:0][3:0] rel;
    logic [3:0]      vbase;
  } vec_t;

  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  int             cnt_model = 0;
  bit             err_model = 1'b0;
  logic [DW-1:0]  fq [4][$];
  logic [DW-1:0]  stg [4];
  logic [DW-1:0]  dreg [4];
  logic [3:0]     empty_r = 4'hF;
  exp_t           sb [$];
  int             popcyc [$];
  logic [1:0]     got_src [$];
  int             got_cyc [$];
  vec_t           vecs [4];

  assign fifo_empty = empty_r;
  assign fifo_data  = {dreg[3], dreg[2], dreg[1], dreg[0]};

  task automatic chk_eq(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upstream FIFO model: two-cycle read latency, empty flag registered from the pre-pop depth.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      int sz;
      sz = fq[i].size();
      empty_r[i] <= (sz == 0);
      dreg[i] <= stg[i];
      if (pop[i]) begin
        chk_eq("pop_of_empty", (sz > 0), 1);
        if (sz > 0) begin
          logic [DW-1:0] w;
          exp_t e;
          w = fq[i].pop_front();
          stg[i] <= w;
          e.src = 2'(i); e.data = w; e.due = 32'(cyc + 3);
          sb.push_back(e);
          popcyc.push_back(cyc);
        end
      end
    end
  end

  // Output checker: scoreboard pop on each push, plus pop legality, counter and error models.
  always @(negedge clk) begin
    if (reset_L) begin
      chk_eq("pop_onehot", $onehot0(pop), 1);
      if (down_pausa || down_full) chk_eq("pop_while_blocked", pop, 0);
      if (push_out) begin
        got_src.push_back(src_id);
        got_cyc.push_back(cyc);
        if (cnt_model < 255) cnt_model++;
        if (sb.size() == 0) begin
          chk_eq("push_unexpected", push_out, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk_eq("push_data", data_out, e.data);
          chk_eq("push_src", src_id, e.src);
          chk_eq("push_cycle", cyc, e.due);
        end
      end
      chk_eq("fwd_count", fwd_count, cnt_model);
      chk_eq("error_flag", error, err_model);
      if (push_out && down_full) err_model = 1'b1;
    end
  end

  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    chk_eq("rst_pop", pop, 0);
    chk_eq("rst_push", push_out, 0);
    chk_eq("rst_data", data_out, 0);
    chk_eq("rst_src", src_id, 0);
    chk_eq("rst_count", fwd_count, 0);
    chk_eq("rst_error", error, 0);
    chk_eq("rst_idle", idle, 1);
    sb.delete(); popcyc.delete(); got_src.delete(); got_cyc.delete();
    for (int i = 0; i < 4; i++) fq[i].delete();
    cnt_model = 0;
    err_model = 1'b0;
    down_pausa = 1'b0;
    down_full = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_L = 1'b1;
  endtask

  task automatic load(input int i, input int n, input logic [3:0] base);
    for (int k = 0; k < n; k++) fq[i].push_back({2'(i), 4'(base + 4'(k))});
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < 4; i++) if (fq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drained(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      if (all_empty() && sb.size() == 0 && idle) break;
    end
    chk_eq("drain_timeout", (k < budget), 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      if (popcyc.size() >= n) break;
    end
    chk_eq("pop_timeout", (k < budget), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, j0, n_in, first_after, n_push;

    // Lone input 2, three words: pops every other cycle.
    vecs[0].cnt = {4'd0, 4'd3, 4'd0, 4'd0}; vecs[0].n = 4'd3; vecs[0].vbase = 4'd5;
    vecs[0].seq = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2};
    vecs[0].rel = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 4'd0};
    // All four busy, input 0 has two words: 0,1,2,3,0 back to back.
    vecs[1].cnt = {4'd1, 4'd1, 4'd1, 4'd2}; vecs[1].n = 4'd5; vecs[1].vbase = 4'd1;
    vecs[1].seq = {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
    vecs[1].rel = {4'd0, 4'd0, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    // Inputs 1 and 3 alternate.
    vecs[2].cnt = {4'd2, 4'd0, 4'd2, 4'd0}; vecs[2].n = 4'd4; vecs[2].vbase = 4'd9;
    vecs[2].seq = {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3, 2'd1};
    vecs[2].rel = {4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    // Input 0 once, input 3 twice: one bubble when only the masked input remains.
    vecs[3].cnt = {4'd2, 4'd0, 4'd0, 4'd1}; vecs[3].n = 4'd3; vecs[3].vbase = 4'd12;
    vecs[3].seq = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0};
    vecs[3].rel = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3, 4'd1, 4'd0};

    #1;
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < 4; i++) load(i, int'(vecs[v].cnt[i]), vecs[v].vbase);
      wait_pops(1, 20);
      chk_eq("idle_after_pop", idle, 0);
      wait_drained(100);
      chk_eq("vec_push_count", got_src.size(), vecs[v].n);
      for (int j = 0; j < int'(vecs[v].n) && j < got_src.size() && j < popcyc.size(); j++) begin
        chk_eq("vec_src_order", got_src[j], vecs[v].seq[j]);
        chk_eq("vec_pop_cycle", popcyc[j] - popcyc[0], vecs[v].rel[j]);
      end
      chk_eq("vec_fwd_count", fwd_count, vecs[v].n);
      chk_eq("vec_idle_end", idle, 1);
    end

    // Pausa during a continuous stream.
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 8, 4'd0);
    wait_pops(4, 20);
    @(posedge clk); #1; down_pausa = 1'b1; k0 = cyc;
    repeat (6) @(posedge clk);
    #1; down_pausa = 1'b0; j0 = cyc;
    wait_drained(100);
    n_in = 0; first_after = -1; n_push = 0;
    foreach (popcyc[p]) begin
      if (popcyc[p] >= k0 && popcyc[p] <= j0) n_in++;
      if (popcyc[p] > j0 && first_after < 0) first_after = popcyc[p];
    end
    foreach (got_cyc[p]) if (got_cyc[p] >= k0 + 1 && got_cyc[p] <= k0 + 5) n_push++;
    chk_eq("pausa_pops_during", n_in, 0);
    chk_eq("pausa_resume_cycle", first_after, j0 + 1);
    chk_eq("pausa_tail_pushes", n_push, 2);
    chk_eq("pausa_total", got_src.size(), 32);

    // Downstream full while words land: pushes still happen, error latches.
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 4, 4'd3);
    wait_pops(3, 20);
    @(posedge clk); #1; down_full = 1'b1; k0 = cyc;
    repeat (3) @(posedge clk);
    #1; down_full = 1'b0;
    wait_drained(100);
    n_push = 0;
    foreach (got_cyc[p]) if (got_cyc[p] >= k0 && got_cyc[p] <= k0 + 2) n_push++;
    chk_eq("full_pushes_landed", n_push, 3);
    chk_eq("error_set", error, 1);
    repeat (5) @(posedge clk);
    #2 chk_eq("error_sticky", error, 1);

    // Reset with pops in flight: those words are dropped.
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 4, 4'd7);
    wait_pops(3, 20);
    do_reset();
    repeat (6) @(posedge clk);
    #2;
    chk_eq("no_push_after_reset", got_cyc.size(), 0);
    chk_eq("count_after_reset", fwd_count, 0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 65, 4'd0);
    wait_drained(600);
    chk_eq("sat_pushes", got_src.size(), 260);
    chk_eq("sat_count", fwd_count, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
